// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
// ex_muldiv: multi-cycle RV32M multiply/divide unit for the EX stage.
// Signed operands are reduced to magnitudes, an unsigned shift-add multiplier
// or restoring divider retires UNROLL bits per cycle, and the result is
// conditionally negated on the final cycle.
// Ports:
//   clk, rst (sync, active-low)  clock / reset
//   flush                        abandon current or offered operation
//   start, op, rs1, rs2, rd_in   operation offer (op = funct3)
//   busy                         registered, high while iterating
//   ex_stall                     combinational pipeline hold
//   done, result, rd_out         registered one-cycle completion
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int RAW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [RAW-1:0]  rd_in,
  output logic            busy,
  output logic            ex_stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RAW-1:0]  rd_out
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [RAW-1:0]    rd_q;
  logic              neg_q;
  // mul: addend |A|; div: divisor |B|
  logic [XLEN-1:0]   opnd;
  // mul: {partial product high, multiplier}; div: {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc, acc_nxt;

  // ---- operand preparation ----
  logic            a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf, fast, neg_in;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  assign a_sgn    = op[2] ? ~op[0] : (op[1:0] != 2'b11);
  assign b_sgn    = op[2] ? ~op[0] : ~op[1];
  assign a_neg    = a_sgn & rs1[XLEN-1];
  assign b_neg    = b_sgn & rs2[XLEN-1];
  assign a_mag    = a_neg ? -rs1 : rs1;
  assign b_mag    = b_neg ? -rs2 : rs2;
  assign div_zero = op[2] & (rs2 == '0);
  assign div_ovf  = op[2] & ~op[0] & (rs1 == MIN_NEG) & (&rs2);
  assign fast     = div_zero | div_ovf;
  // op[1] selects remainder for the divide ops
  assign fast_res = op[1] ? (div_zero ? rs1 : '0) : (div_zero ? '1 : rs1);
  // remainder takes the dividend sign; product and quotient take the XOR
  assign neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);

  assign ex_stall = rst & ((state == S_CALC) | (start & ~flush));

  // ---- iteration datapath ----
  logic [XLEN:0] rem_sh, sum;

  always_comb begin
    acc_nxt = acc;
    rem_sh  = '0;
    sum     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rem_sh = {acc_nxt[2*XLEN-1:XLEN], acc_nxt[XLEN-1]};
        acc_nxt[XLEN-1:0] = {acc_nxt[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, opnd}) begin
          rem_sh     = rem_sh - {1'b0, opnd};
          acc_nxt[0] = 1'b1;
        end
        acc_nxt[2*XLEN-1:XLEN] = rem_sh[XLEN-1:0];
      end else begin
        sum     = {1'b0, acc_nxt[2*XLEN-1:XLEN]} + (acc_nxt[0] ? {1'b0, opnd} : '0);
        acc_nxt = {sum, acc_nxt[XLEN-1:1]};
      end
    end
  end

  // ---- final sign fix-up and result select ----
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   dsel, dres, fin;

  assign prod = neg_q ? -acc_nxt : acc_nxt;
  assign dsel = op_q[1] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
  assign dres = neg_q ? -dsel : dsel;
  assign fin  = op_q[2] ? dres :
                (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      neg_q  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else if (state == S_CALC) begin
        acc <= acc_nxt;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          result <= fin;
          rd_out <= rd_q;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end
      end else if (start) begin
        op_q  <= op;
        rd_q  <= rd_in;
        neg_q <= neg_in;
        if (fast) begin
          result <= fast_res;
          rd_out <= rd_in;
          done   <= 1'b1;
          state  <= S_DONE;
        end else begin
          opnd  <= op[2] ? b_mag : a_mag;
          acc   <= {{XLEN{1'b0}}, (op[2] ? a_mag : b_mag)};
          cnt   <= CW'(N);
          busy  <= 1'b1;
          state <= S_CALC;
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
`timescale 1ns/1ps
module tb_ex_muldiv;

  typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [4:0] rd; } stim_t;
  typedef struct { logic [31:0] res; logic [4:0] rd; bit fast; } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [2:0]  start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  rd_in;
  logic [2:0]  busy, ex_stall, done;
  logic [31:0] result [3];
  logic [4:0]  rd_out [3];

  stim_t       stim[$];
  exp_t        sb[$];
  logic [31:0] last_res [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .UNROLL(1),  .RAW(5)) u0 (.clk(clk), .rst(rst), .flush(flush),
    .start(start[0]), .op(op), .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .busy(busy[0]),
    .ex_stall(ex_stall[0]), .done(done[0]), .result(result[0]), .rd_out(rd_out[0]));
  ex_muldiv #(.XLEN(32), .UNROLL(4),  .RAW(5)) u1 (.clk(clk), .rst(rst), .flush(flush),
    .start(start[1]), .op(op), .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .busy(busy[1]),
    .ex_stall(ex_stall[1]), .done(done[1]), .result(result[1]), .rd_out(rd_out[1]));
  ex_muldiv #(.XLEN(32), .UNROLL(32), .RAW(5)) u2 (.clk(clk), .rst(rst), .flush(flush),
    .start(start[2]), .op(op), .rs1(rs1), .rs2(rs2), .rd_in(rd_in), .busy(busy[2]),
    .ex_stall(ex_stall[2]), .done(done[2]), .result(result[2]), .rd_out(rd_out[2]));

  function automatic int n_of(input int idx);
    case (idx)
      0:       return 32;
      1:       return 8;
      default: return 1;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    return o[2] && ((b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference built on 64-bit language arithmetic, independent of the iterative core.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbb, zb, p;
    logic [63:0]        up;
    logic signed [31:0] q;
    bit                 ovf;
    sa  = {{32{a[31]}}, a};
    sbb = {{32{b[31]}}, b};
    zb  = {32'd0, b};
    up  = {32'd0, a} * {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: return up[31:0];
      3'd1: begin p = sa * sbb; return p[63:32]; end
      3'd2: begin p = sa * zb;  return p[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic add_stim(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
    stim_t s;
    s.op = o; s.a = a; s.b = b; s.rd = r;
    stim.push_back(s);
  endtask

  task automatic drive_op(input int idx, input stim_t s);
    exp_t e;
    op = s.op; rs1 = s.a; rs2 = s.b; rd_in = s.rd;
    start[idx] = 1'b1;
    e.res  = ref_model(s.op, s.a, s.b);
    e.rd   = s.rd;
    e.fast = is_fast(s.op, s.a, s.b);
    sb.push_back(e);
  endtask

  // Observes one completion; lat = cycles from the accept cycle to done (-1 on timeout).
  task automatic wait_done(input int idx, output int lat, output logic [31:0] r, output logic [4:0] d,
                           output bit calc_ok, output logic busy_d, output logic stall_d);
    lat = -1; r = '0; d = '0; calc_ok = 1'b1; busy_d = 1'b0; stall_d = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done[idx]) begin
        lat = c; r = result[idx]; d = rd_out[idx]; busy_d = busy[idx]; stall_d = ex_stall[idx];
        return;
      end
      if (!busy[idx] || !ex_stall[idx]) calc_ok = 1'b0;
    end
  endtask

  task automatic run_stream(input int idx, input string tag, input bit b2b);
    int lat, want; logic [31:0] r; logic [4:0] d; bit cok; logic bd, sd; stim_t s; exp_t e;
    @(negedge clk);
    s = stim.pop_front();
    drive_op(idx, s);
    #1;
    checks++;
    if (ex_stall[idx] !== 1'b1) begin
      errors++; $display("FAIL %s accept_stall dut%0d got %b want 1", tag, idx, ex_stall[idx]);
    end
    while (1) begin
      if (!b2b) begin @(posedge clk); #1 start[idx] = 1'b0; end
      wait_done(idx, lat, r, d, cok, bd, sd);
      e = sb.pop_front();
      want = e.fast ? 1 : n_of(idx) + 1;
      checks++;
      if (lat != want) begin
        errors++; $display("FAIL %s latency dut%0d got %0d want %0d", tag, idx, lat, want);
      end
      checks++;
      if (r !== e.res) begin
        errors++; $display("FAIL %s result dut%0d got %h want %h", tag, idx, r, e.res);
      end
      checks++;
      if (d !== e.rd) begin
        errors++; $display("FAIL %s rd_out dut%0d got %0d want %0d", tag, idx, d, e.rd);
      end
      checks++;
      if (e.fast ? (bd !== 1'b0) : (cok !== 1'b1)) begin
        errors++; $display("FAIL %s busy_stall dut%0d got busy_at_done=%b calc_ok=%b want fast=%b", tag, idx, bd, cok, e.fast);
      end
      checks++;
      if (sd !== b2b) begin
        errors++; $display("FAIL %s done_stall dut%0d got %b want %b", tag, idx, sd, b2b);
      end
      last_res[idx] = e.res;
      if (stim.size() == 0) begin start[idx] = 1'b0; break; end
      s = stim.pop_front();
      if (!b2b) @(negedge clk);
      drive_op(idx, s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; start = 3'b111;
    op = 3'd0; rs1 = 32'd5; rs2 = 32'd3; rd_in = 5'd7;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, done, ex_stall} !== 9'd0) begin
        errors++; $display("FAIL reset flags got %b want 0", {busy, done, ex_stall});
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (result[i] !== 32'd0 || rd_out[i] !== 5'd0) begin
          errors++; $display("FAIL reset outputs dut%0d got %h/%0d want 0/0", i, result[i], rd_out[i]);
        end
      end
    end
    @(negedge clk);
    start = 3'b000; rst = 1'b1;
    for (int i = 0; i < 3; i++) last_res[i] = 32'd0;
  endtask

  task automatic test_mul();
    add_stim(3'd0, 32'hFFFF_FFFE, 32'h3, 5'd1);
    add_stim(3'd1, 32'hFFFF_FFFE, 32'h3, 5'd2);
    add_stim(3'd3, 32'hFFFF_FFFE, 32'h3, 5'd3);
    add_stim(3'd2, 32'hFFFF_FFFE, 32'h3, 5'd4);
    run_stream(0, "mul", 1'b0);
  endtask

  task automatic test_div();
    add_stim(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd5);
    add_stim(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd6);
    add_stim(3'd5, 32'hFFFF_FFF9, 32'h2, 5'd7);
    add_stim(3'd7, 32'hFFFF_FFF9, 32'h2, 5'd8);
    run_stream(0, "div", 1'b0);
  endtask

  task automatic test_fast();
    add_stim(3'd5, 32'd5,          32'd0,          5'd10);
    add_stim(3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11);
    add_stim(3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12);
    add_stim(3'd7, 32'h1234_5678,  32'd0,          5'd13);
    run_stream(0, "fast", 1'b0);
  endtask

  task automatic test_reset_mid();
    bit saw = 1'b0;
    @(negedge clk);
    op = 3'd4; rs1 = 32'd100; rs2 = 32'd3; rd_in = 5'd21; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || ex_stall[0] !== 1'b0 || result[0] !== 32'd0 || rd_out[0] !== 5'd0) begin
      errors++; $display("FAIL reset_mid outputs got busy=%b done=%b stall=%b res=%h rd=%0d want all 0",
                         busy[0], done[0], ex_stall[0], result[0], rd_out[0]);
    end
    @(negedge clk); rst = 1'b1;
    repeat (40) begin @(negedge clk); if (done[0]) saw = 1'b1; end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL reset_mid stray_done got 1 want 0"); end
    last_res[0] = 32'd0;
  endtask

  task automatic test_flush();
    bit saw = 1'b0, bz_ok = 1'b1, cok; int lat; logic [31:0] r; logic [4:0] d; logic bd, sd;
    stim_t s; exp_t e;
    // give the result register a known non-zero value first
    add_stim(3'd1, 32'h7000_0001, 32'h7000_0003, 5'd14);
    run_stream(0, "flush_pre", 1'b0);
    @(negedge clk);
    op = 3'd4; rs1 = 32'd1000; rs2 = 32'd7; rd_in = 5'd9; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done[0]) saw = 1'b1;
      if (!busy[0]) bz_ok = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (bz_ok !== 1'b1 || saw !== 1'b0) begin
      errors++; $display("FAIL flush calc got busy_ok=%b saw_done=%b want 1/0", bz_ok, saw);
    end
    checks++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || ex_stall[0] !== 1'b0) begin
      errors++; $display("FAIL flush idle got busy=%b done=%b stall=%b want 0", busy[0], done[0], ex_stall[0]);
    end
    checks++;
    if (result[0] !== last_res[0] || rd_out[0] !== 5'd14) begin
      errors++; $display("FAIL flush hold got %h/%0d want %h/14", result[0], rd_out[0], last_res[0]);
    end
    s.op = 3'd6; s.a = 32'hFFFF_FC18; s.b = 32'd7; s.rd = 5'd15;
    drive_op(0, s);
    @(posedge clk); #1 start[0] = 1'b0;
    wait_done(0, lat, r, d, cok, bd, sd);
    e = sb.pop_front();
    checks++;
    if (lat != 33) begin errors++; $display("FAIL flush restart_latency got %0d want 33", lat); end
    checks++;
    if (r !== e.res || d !== e.rd) begin
      errors++; $display("FAIL flush restart_result got %h/%0d want %h/%0d", r, d, e.res, e.rd);
    end
    last_res[0] = e.res;
  endtask

  task automatic test_back_to_back();
    for (int idx = 0; idx < 3; idx++) begin
      add_stim(3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5'd16);
      add_stim(3'd4, 32'hDEAD_BEEF, 32'h0000_0000, 5'd17);
      add_stim(3'd4, 32'h8000_0001, 32'hFFFF_FFF3, 5'd18);
      add_stim(3'd2, 32'h8765_4321, 32'hF000_000F, 5'd19);
      run_stream(idx, "b2b", 1'b1);
    end
  endtask

  task automatic test_random();
    int cnt;
    for (int idx = 0; idx < 3; idx++) begin
      cnt = (idx == 0) ? 100 : (idx == 1) ? 500 : 10000;
      for (int i = 0; i < cnt; i++)
        add_stim(3'($urandom_range(0, 7)), rnd_val(), rnd_val(), 5'($urandom_range(0, 31)));
      run_stream(idx, "random", 1'b1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_reset_mid();
    test_flush();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
